// File: rtl/cmd_slave_regfile.sv
// cmd_slave_regfile: slave-side consumer of the cmd/adr/data bus.
// Executes one command per clock against a 2**AW x DW register file:
// write, read, increment (read-modify-write) and a clear-all sweep.
// The bus has no back-pressure, so commands arriving while busy are
// dropped and counted.
module cmd_slave_regfile #(
  parameter int AW      = 4,
  parameter int DW      = 4,
  parameter int CW      = 4,
  parameter bit INC_SAT = 1'b1,
  parameter int DCW     = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [CW-1:0]  cmd,
  input  logic [AW-1:0]  adr,
  input  logic [DW-1:0]  data,
  output logic [DW-1:0]  rdata,
  output logic           rvalid,
  output logic           err,
  output logic           busy,
  output logic [DCW-1:0] drop_cnt
);

  localparam int DEPTH = 2**AW;

  localparam logic [CW-1:0] CMD_NOP = CW'(0);
  localparam logic [CW-1:0] CMD_WR  = CW'(1);
  localparam logic [CW-1:0] CMD_RD  = CW'(2);
  localparam logic [CW-1:0] CMD_INC = CW'(3);
  localparam logic [CW-1:0] CMD_CLR = CW'(4);

  typedef enum logic [1:0] {S_IDLE, S_RMW, S_CLR} state_t;

  state_t                    state_q, state_d;
  logic [DEPTH-1:0][DW-1:0]  mem_q, mem_d;
  logic [DW-1:0]             rdata_q, rdata_d;
  logic                      rvalid_q, rvalid_d;
  logic                      err_q, err_d;
  logic                      busy_q, busy_d;
  logic [DCW-1:0]            drop_cnt_q, drop_cnt_d;
  logic [AW-1:0]             clr_ptr_q, clr_ptr_d;
  logic [AW-1:0]             inc_adr_q, inc_adr_d;
  logic [DW-1:0]             inc_old_q, inc_old_d;
  logic [DW-1:0]             inc_val;

  // Increment result: saturate at all-ones or wrap, chosen at elaboration.
  always_comb begin
    if (INC_SAT && (inc_old_q == {DW{1'b1}})) inc_val = inc_old_q;
    else                                      inc_val = inc_old_q + DW'(1);
  end

  // Next-state, register-file update and output pulses.
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    err_d      = 1'b0;
    drop_cnt_d = drop_cnt_q;
    clr_ptr_d  = clr_ptr_q;
    inc_adr_d  = inc_adr_q;
    inc_old_d  = inc_old_q;
    case (state_q)
      S_IDLE: begin
        case (cmd)
          CMD_NOP: ;
          CMD_WR:  mem_d[adr] = data;
          CMD_RD: begin
            rdata_d  = mem_q[adr];
            rvalid_d = 1'b1;
          end
          CMD_INC: begin
            inc_adr_d = adr;
            inc_old_d = mem_q[adr];
            state_d   = S_RMW;
          end
          CMD_CLR: begin
            clr_ptr_d = '0;
            state_d   = S_CLR;
          end
          default: err_d = 1'b1;
        endcase
      end
      S_RMW: begin
        mem_d[inc_adr_q] = inc_val;
        rdata_d          = inc_val;
        rvalid_d         = 1'b1;
        state_d          = S_IDLE;
      end
      S_CLR: begin
        mem_d[clr_ptr_q] = '0;
        clr_ptr_d        = clr_ptr_q + AW'(1);
        if (clr_ptr_q == {AW{1'b1}}) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Busy: the command is ignored but a non-NOP one is counted as dropped.
    if ((state_q != S_IDLE) && (cmd != CMD_NOP) && (drop_cnt_q != {DCW{1'b1}}))
      drop_cnt_d = drop_cnt_q + DCW'(1);
    busy_d = (state_d != S_IDLE);
  end

  // State and register-file flops; reset discards any partial RMW or sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mem_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      drop_cnt_q <= '0;
      clr_ptr_q  <= '0;
      inc_adr_q  <= '0;
      inc_old_q  <= '0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      drop_cnt_q <= drop_cnt_d;
      clr_ptr_q  <= clr_ptr_d;
      inc_adr_q  <= inc_adr_d;
      inc_old_q  <= inc_old_d;
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_cmd_slave_regfile.sv
// Directed bench for cmd_slave_regfile: one saturating and one wrapping
// instance share all inputs; outputs are checked against hand values.
module tb_cmd_slave_regfile;

  localparam logic [3:0] NOP = 4'd0, WR = 4'd1, RD = 4'd2, INC = 4'd3, CLR = 4'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cmd = '0, adr = '0, data = '0;

  logic [3:0] rdata_s, rdata_w;
  logic       rvalid_s, rvalid_w, err_s, err_w, busy_s, busy_w;
  logic [7:0] drop_s, drop_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmd_slave_regfile #(.AW(4), .DW(4), .CW(4), .INC_SAT(1'b1), .DCW(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .adr(adr), .data(data),
    .rdata(rdata_s), .rvalid(rvalid_s), .err(err_s), .busy(busy_s), .drop_cnt(drop_s)
  );

  cmd_slave_regfile #(.AW(4), .DW(4), .CW(4), .INC_SAT(1'b0), .DCW(8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .adr(adr), .data(data),
    .rdata(rdata_w), .rvalid(rvalid_w), .err(err_w), .busy(busy_w), .drop_cnt(drop_w)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one command at the falling edge; return 1 time unit after the rising edge.
  task automatic cyc(input logic [3:0] c, input logic [3:0] a, input logic [3:0] d);
    @(negedge clk);
    cmd = c; adr = a; data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    cmd = NOP; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Register i gets (i % 15) + 1, never zero.
  task automatic fill();
    for (int i = 0; i < 16; i++) cyc(WR, 4'(i), 4'((i % 15) + 1));
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_rdata",  {28'd0, rdata_s}, 0);
    chk("rst_rvalid", {31'd0, rvalid_s}, 0);
    chk("rst_err",    {31'd0, err_s}, 0);
    chk("rst_busy",   {31'd0, busy_s}, 0);
    chk("rst_drop",   {24'd0, drop_s}, 0);
    do_reset();

    // Write then read-back
    cyc(WR, 4'd3, 4'd9);
    chk("wr_rvalid", {31'd0, rvalid_s}, 0);
    cyc(RD, 4'd3, 4'd0);
    chk("rd_rvalid", {31'd0, rvalid_s}, 1);
    chk("rd_rdata",  {28'd0, rdata_s}, 9);
    cyc(NOP, 4'd0, 4'd0);
    chk("rd_pulse_end", {31'd0, rvalid_s}, 0);
    chk("rd_hold",      {28'd0, rdata_s}, 9);

    // INC twice from 14: saturating 15,15; wrapping 15,0
    cyc(WR, 4'd5, 4'd14);
    cyc(INC, 4'd5, 4'd0);
    chk("inc1_busy",   {31'd0, busy_s}, 1);
    chk("inc1_rvalid", {31'd0, rvalid_s}, 0);
    cyc(NOP, 4'd0, 4'd0);
    chk("inc1_rvalid2", {31'd0, rvalid_s}, 1);
    chk("inc1_sat",     {28'd0, rdata_s}, 15);
    chk("inc1_wrap",    {28'd0, rdata_w}, 15);
    chk("inc1_idle",    {31'd0, busy_s}, 0);
    cyc(INC, 4'd5, 4'd0);
    chk("inc2_busy", {31'd0, busy_w}, 1);
    cyc(NOP, 4'd0, 4'd0);
    chk("inc2_sat",  {28'd0, rdata_s}, 15);
    chk("inc2_wrap", {28'd0, rdata_w}, 0);
    chk("nop_busy_drop", {24'd0, drop_s}, 0);
    cyc(RD, 4'd5, 4'd0);
    chk("inc_mem_sat",  {28'd0, rdata_s}, 15);
    chk("inc_mem_wrap", {28'd0, rdata_w}, 0);

    // INC followed by a WRITE that must be dropped
    cyc(WR, 4'd2, 4'd6);
    cyc(INC, 4'd2, 4'd0);
    cyc(WR, 4'd2, 4'd1);
    chk("drop_wr_cnt",   {24'd0, drop_s}, 1);
    chk("drop_wr_rdata", {28'd0, rdata_s}, 7);
    cyc(RD, 4'd2, 4'd0);
    chk("drop_wr_mem", {28'd0, rdata_s}, 7);

    // Clear sweep with READ driven every cycle
    do_reset();
    fill();
    cyc(RD, 4'd7, 4'd0);
    chk("fill_rd7", {28'd0, rdata_s}, 8);
    cyc(CLR, 4'd0, 4'd0);
    chk("clr_busy0", {31'd0, busy_s}, 1);
    for (int k = 1; k <= 16; k++) begin
      cyc(RD, 4'(k), 4'd0);
      chk($sformatf("clr_busy%0d", k), {31'd0, busy_s}, (k < 16) ? 1 : 0);
      chk($sformatf("clr_rv%0d", k), {31'd0, rvalid_s}, 0);
    end
    chk("clr_drop", {24'd0, drop_s}, 16);
    for (int i = 0; i < 16; i++) begin
      cyc(RD, 4'(i), 4'd0);
      chk($sformatf("clr_mem%0d", i), {27'd0, rvalid_s, rdata_s}, 32'h10);
    end

    // Illegal command, then NOP while busy
    cyc(WR, 4'd4, 4'd10);
    cyc(4'd7, 4'd4, 4'd3);
    chk("ill_err",    {31'd0, err_s}, 1);
    chk("ill_rvalid", {31'd0, rvalid_s}, 0);
    cyc(RD, 4'd4, 4'd0);
    chk("ill_err_end", {31'd0, err_s}, 0);
    chk("ill_mem",     {28'd0, rdata_s}, 10);
    cyc(INC, 4'd4, 4'd0);
    cyc(NOP, 4'd0, 4'd0);
    chk("nop_drop",  {24'd0, drop_s}, 16);
    chk("inc4_val",  {28'd0, rdata_s}, 11);

    // Drop counter saturation: 16 more sweeps of 16 drops each
    for (int r = 0; r < 16; r++) begin
      cyc(CLR, 4'd0, 4'd0);
      for (int k = 0; k < 16; k++) cyc(RD, 4'd0, 4'd0);
    end
    chk("drop_sat", {24'd0, drop_s}, 255);
    chk("drop_sat_idle", {31'd0, busy_s}, 0);

    // Reset in the middle of a sweep
    do_reset();
    fill();
    cyc(RD, 4'd7, 4'd0);
    cyc(CLR, 4'd0, 4'd0);
    for (int k = 0; k < 5; k++) cyc(RD, 4'd0, 4'd0);
    chk("mid_busy", {31'd0, busy_s}, 1);
    chk("mid_drop", {24'd0, drop_s}, 5);
    @(negedge clk);
    rst_n = 1'b0; cmd = NOP;
    #1;
    chk("mid_rst_busy",  {31'd0, busy_s}, 0);
    chk("mid_rst_drop",  {24'd0, drop_s}, 0);
    chk("mid_rst_rdata", {28'd0, rdata_s}, 0);
    chk("mid_rst_rv",    {31'd0, rvalid_s}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(RD, 4'd10, 4'd0);
    chk("post_rst_rd10", {27'd0, rvalid_s, rdata_s}, 32'h10);
    cyc(RD, 4'd2, 4'd0);
    chk("post_rst_rd2",  {27'd0, rvalid_s, rdata_s}, 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
